multireceive: RTL and testbench

- Receiving end of the digit-serial link driven by multisend/sender on the far board.
- Watches the three data lines and the control strobe, and captures one 3-bit digit per control pulse.
- Assembles NUM_DIGITS digits into a word and flags completion.
- Sits at the input of the keylock compare logic; all link inputs are asynchronous to hwclk.

---
 rtl/multireceive_pkg.sv | 17 +
 rtl/multireceive_sync2.sv | 27 ++
 rtl/multireceive.sv | 161 ++++++++++++++++
 tb/tb_multireceive.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multireceive_pkg.sv
// Shared definitions for the digit-serial link (receiver side, shared with sender).
package multireceive_pkg;

    localparam int unsigned DIGIT_W     = 3;
    localparam int unsigned HOLD_CYCLES = 1200000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_HIGH,
        SETTLE,
        WAIT_LOW,
        COMPLETE,
        ERROR
    } state_t;

endpackage

// File: rtl/multireceive_sync2.sv
// Parameterised-width two-flop synchronizer with synchronous active-low clear.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops to resolve metastability on asynchronous inputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/multireceive.sv
// Receiver for the digit-serial keylock link: one 3-bit digit per control pulse,
// NUM_DIGITS digits per frame, with glitch filter and inter-edge timeout.
module multireceive
    import multireceive_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 3600000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic                          hwclk,
    input  logic                          rst_n,
    input  logic                          enabled,
    input  logic                          in0,
    input  logic                          in1,
    input  logic                          in2,
    input  logic                          controlIn,
    output logic [DIGIT_W*NUM_DIGITS-1:0] num,
    output logic                          valid,
    output logic                          done,
    output logic                          timeout_err
);

    localparam int unsigned    IDX_W        = $clog2(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]         sync_w;
    logic               ctrl_s;
    logic [DIGIT_W-1:0] data_s;
    logic               ctrl_prev_q;
    logic               rise;
    logic               fall;

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [DIGIT_W-1:0]          shadow_q [NUM_DIGITS];
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_flat;
    logic [DIGIT_W*NUM_DIGITS-1:0] num_q;
    logic                        valid_q;
    logic                        done_q;
    logic                        timeout_q;

    sync2 #(
        .WIDTH(4)
    ) u_sync (
        .clk_i  (hwclk),
        .rst_ni (rst_n),
        .d_i    ({controlIn, in2, in1, in0}),
        .q_o    (sync_w)
    );

    assign ctrl_s = sync_w[3];
    assign data_s = sync_w[2:0];
    assign rise   = ctrl_s & ~ctrl_prev_q;
    assign fall   = ~ctrl_s & ctrl_prev_q;

    // Pack shadow digits so the first received digit lands in the MS bits.
    always_comb begin
        shadow_flat = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            shadow_flat[DIGIT_W*(NUM_DIGITS-k)-1 -: DIGIT_W] = shadow_q[k];
        end
    end

    // Frame FSM with registered outputs; enabled=0 overrides every other event.
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            ctrl_prev_q <= 1'b0;
            num_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) shadow_q[k] <= '0;
        end else begin
            ctrl_prev_q <= ctrl_s;
            valid_q     <= 1'b0;
            if (!enabled) begin
                state_q   <= IDLE;
                idx_q     <= '0;
                cnt_q     <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: begin
                        // A strobe already high when armed is stale; wait for it to drop.
                        if (!ctrl_s) begin
                            state_q <= WAIT_HIGH;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            for (int unsigned k = 0; k < NUM_DIGITS; k++) shadow_q[k] <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rise) begin
                            state_q <= SETTLE;
                            cnt_q   <= '0;
                        end else if (idx_q != '0) begin
                            if (cnt_q == TIMEOUT_LAST) begin
                                state_q   <= ERROR;
                                timeout_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (!ctrl_s) begin
                            state_q <= WAIT_HIGH;
                            cnt_q   <= '0;
                        end else if (cnt_q == SETTLE_LAST) begin
                            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                                if (idx_q == IDX_W'(k)) shadow_q[k] <= data_s;
                            end
                            state_q <= WAIT_LOW;
                            cnt_q   <= cnt_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WAIT_LOW: begin
                        // Timeout keeps counting from the rising edge until the falling edge.
                        if (fall) begin
                            cnt_q <= '0;
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == LAST_IDX) begin
                                state_q <= COMPLETE;
                                num_q   <= shadow_flat;
                                valid_q <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT_HIGH;
                            end
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            state_q   <= ERROR;
                            timeout_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    COMPLETE: state_q <= COMPLETE;
                    ERROR:    state_q <= ERROR;
                    default:  state_q <= IDLE;
                endcase
            end
        end
    end

    assign num         = num_q;
    assign valid       = valid_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_multireceive.sv
// Scoreboard bench for multireceive: expected frames queued by stimulus, popped on valid.
module tb_multireceive;
    import multireceive_pkg::*;

    localparam int unsigned ND = 6;
    localparam int unsigned W  = DIGIT_W * ND;

    logic         hwclk = 1'b0;
    logic         rst_n;
    logic         enabled;
    logic         in0, in1, in2;
    logic         controlIn;
    logic [W-1:0] num;
    logic         valid, done, timeout_err;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q [$];
    int unsigned  n_to;

    always #5 hwclk = ~hwclk;

    multireceive #(
        .NUM_DIGITS     (ND),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (22)
    ) dut (
        .hwclk       (hwclk),
        .rst_n       (rst_n),
        .enabled     (enabled),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .controlIn   (controlIn),
        .num         (num),
        .valid       (valid),
        .done        (done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0o required=%0o", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued frame.
    always @(negedge hwclk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual num=%0o required=no valid", num);
            end else begin
                check("frame_num", 32'(num), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic send_digit(input logic [2:0] d, input int unsigned hi, input int unsigned lo);
        {in2, in1, in0} = d;
        controlIn = 1'b1;
        tick(hi);
        controlIn = 1'b0;
        tick(lo);
    endtask

    task automatic send_frame(input logic [W-1:0] f);
        for (int k = 0; k < int'(ND); k++) begin
            send_digit(f[3*(ND-k)-1 -: 3], 10, 10);
        end
    endtask

    task automatic rearm();
        enabled = 1'b0;
        tick(3);
        enabled = 1'b1;
        tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enabled = 1'b0; controlIn = 1'b0;
        in0 = 1'b0; in1 = 1'b0; in2 = 1'b0;
        tick(3);
        check("rst_num", 32'(num), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick(2);

        // Nominal frame
        enabled = 1'b1;
        tick(4);
        exp_q.push_back(18'o123456);
        send_frame(18'o123456);
        tick(5);
        check("nom_done", 32'(done), 1);
        check("nom_num", 32'(num), 32'(18'o123456));
        check("nom_timeout", 32'(timeout_err), 0);
        enabled = 1'b0;
        tick(3);
        check("done_cleared", 32'(done), 0);

        // Glitch between digits 2 and 3
        enabled = 1'b1;
        tick(4);
        exp_q.push_back(18'o123456);
        send_digit(3'd1, 10, 10);
        send_digit(3'd2, 10, 10);
        send_digit(3'd7, 2, 10);
        send_digit(3'd3, 10, 10);
        send_digit(3'd4, 10, 10);
        send_digit(3'd5, 10, 10);
        send_digit(3'd6, 10, 10);
        tick(5);
        check("glitch_done", 32'(done), 1);
        check("glitch_num", 32'(num), 32'(18'o123456));

        // Timeout after 3 digits
        rearm();
        send_digit(3'd1, 10, 10);
        send_digit(3'd2, 10, 10);
        send_digit(3'd3, 10, 10);
        tick(35);
        check("timeout_not_early", 32'(timeout_err), 0);
        n_to = 45;
        while (timeout_err !== 1'b1 && n_to < 70) begin
            tick(1);
            n_to++;
        end
        check("timeout_seen", 32'(timeout_err), 1);
        check("timeout_latency_min", 32'(n_to >= 51), 1);
        check("timeout_latency_max", 32'(n_to <= 54), 1);
        check("timeout_done", 32'(done), 0);
        check("timeout_num", 32'(num), 32'(18'o123456));

        // Stale strobe held high while arming
        enabled = 1'b0;
        tick(3);
        {in2, in1, in0} = 3'd5;
        controlIn = 1'b1;
        tick(2);
        enabled = 1'b1;
        tick(20);
        check("stale_done", 32'(done), 0);
        check("stale_timeout", 32'(timeout_err), 0);
        controlIn = 1'b0;
        tick(10);
        exp_q.push_back(18'o234567);
        send_frame(18'o234567);
        tick(5);
        check("stale_frame_done", 32'(done), 1);
        check("stale_frame_num", 32'(num), 32'(18'o234567));

        // Abort after 4 digits, then re-arm
        rearm();
        send_digit(3'd1, 10, 10);
        send_digit(3'd2, 10, 10);
        send_digit(3'd3, 10, 10);
        send_digit(3'd4, 10, 10);
        enabled = 1'b0;
        tick(3);
        check("abort_done", 32'(done), 0);
        check("abort_timeout", 32'(timeout_err), 0);
        check("abort_num", 32'(num), 32'(18'o234567));
        enabled = 1'b1;
        tick(4);
        exp_q.push_back(18'o777000);
        send_frame(18'o777000);
        tick(5);
        check("rearm_done", 32'(done), 1);
        check("rearm_num", 32'(num), 32'(18'o777000));

        // Reset during SETTLE
        rearm();
        send_digit(3'd1, 10, 10);
        {in2, in1, in0} = 3'd3;
        controlIn = 1'b1;
        tick(4);
        check("pre_rst_state", 32'(dut.state_q), 32'(SETTLE));
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_num", 32'(num), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_timeout", 32'(timeout_err), 0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        enabled = 1'b0;
        controlIn = 1'b0;
        tick(10);

        check("frames_outstanding", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
